demux_destino: RTL and testbench
================================

Name: demux_destino

Overview:
- Egress-side consumer of the round-robin arbiter's output stream.
- Accepts one 10-bit word per cycle on push_in/data_in and buffers it in a small in-order FIFO.
- Routes each word to one of four egress FIFOs (E0..E3) according to the destination field in its two MSBs, honouring each egress FIFO's almost_full backpressure.
- Provides per-destination delivery counters and a drop counter for verification and debug.

Parameters:
DATA_WIDTH, 10, word width; destination field = data[DATA_WIDTH-1:DATA_WIDTH-2]
BUF_DEPTH, 4, holding-buffer entries (power of 2, >=2)
CNT_WIDTH, 8, width of delivery/drop counters

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
push_in  input  1  upstream write strobe (from arbiter push)
data_in  input  DATA_WIDTH  upstream word
stall  output  1  combinational: buffer full (count==BUF_DEPTH)
almost_full_E0..almost_full_E3  input  1 each  egress FIFO backpressure
push_E0..push_E3  output  1 each  registered egress write strobes
data_out_E0..data_out_E3  output  DATA_WIDTH each  registered egress data
cnt_E0..cnt_E3  output  CNT_WIDTH each  words delivered per destination
drop_cnt  output  CNT_WIDTH  words rejected while stall=1
state  output  2  00 IDLE, 01 ACTIVE, 10 BLOCKED

Behaviour:
- Reset (async, immediate):
  - All push_E*=0; data_out_E*=0; all counters 0.
  - Buffer emptied: count=0, read/write pointers 0; state=IDLE.
  - Reset mid-stream discards buffered words without delivering them.
- Write side:
  - push_in=1 and stall=0: data_in is written at the buffer tail and count increments.
  - push_in=1 and stall=1: word is dropped; drop_cnt increments and saturates at 2^CNT_WIDTH-1.
- Head/destination: head word = oldest entry; d = head[DATA_WIDTH-1:DATA_WIDTH-2].
- Delivery, evaluated each edge when count>0:
  - If almost_full_Ed=0: next-cycle push_Ed=1, data_out_Ed=head, head popped, cnt_Ed increments (wraps modulo 2^CNT_WIDTH).
  - All other push_E* are 0 in that cycle.
- Blocking and ordering:
  - If almost_full_Ed=1: no pop and all push_E*=0. Strict in-order delivery; head-of-line blocking is intended.
  - data_out_E* retain their last delivered value whenever push is low.
- Latency: a word written at edge k into an empty buffer with its destination not almost_full drives push_Ed=1 during the cycle after edge k+1. Sustained throughput is 1 word/cycle.
- Simultaneous write and pop: count unchanged. stall depends on count only, so when full, a same-cycle pop does not admit the incoming word; that word is dropped.
- Pointers wrap modulo BUF_DEPTH.
- State (registered, next-state from post-update count/head):
  - IDLE: count==0. Goes to ACTIVE on any accepted write.
  - ACTIVE: count>0 and head destination not almost_full. Goes to BLOCKED when head destination is almost_full; goes to IDLE when the last entry pops with no write.
  - BLOCKED: count>0 and head destination almost_full. Returns to ACTIVE when that almost_full deasserts.
- almost_full on a non-head destination has no effect.

Test Plan:
- Reset then push_in=1, data_in=10'h2A5 (dest 2), all almost_full=0 -> two edges later push_E2=1 for one cycle, data_out_E2=10'h2A5, cnt_E2=1, other pushes 0.
- Back-to-back writes 10'h001, 10'h102, 10'h203, 10'h304 -> push_E0..E3 asserted on consecutive cycles in that order; each cnt_E*=1; state returns to IDLE.
- almost_full_E1=1; write 10'h155 then 10'h0AA -> state=BLOCKED, no push_E0 despite E0 free (HOL). Deassert almost_full_E1 -> push_E1 (10'h155), then push_E0 (10'h0AA).
- Hold almost_full_E3=1; write six dest-3 words -> stall=1 after the 4th; words 5 and 6 dropped, drop_cnt=2. Release -> exactly 4 words delivered, in order.
- Deliver 256 words to E0 -> cnt_E0 wraps to 0. Force 300 drops -> drop_cnt=255 (saturated).
- Assert reset asynchronously (mid-cycle) with 3 words buffered -> outputs and counters 0 immediately, state=IDLE; no further push_E* after release until a new write.

Source files
------------

// File: rtl/demux_destino.sv
// demux_destino
// Egress-side consumer of the round-robin arbiter output stream. Incoming
// words are buffered in a small in-order FIFO and delivered one per cycle to
// one of four egress FIFOs, chosen by the two MSBs of the word. Delivery of
// the head word waits while its egress FIFO reports almost_full. Words behind
// a blocked head also wait, so ordering is strictly preserved.
//
// Ports:
//   clk, reset                      clock (rising edge), async active-high reset
//   push_in, data_in                upstream write strobe and word
//   stall                           buffer full; a word pushed now is dropped
//   almost_full_E0..E3              egress backpressure
//   push_E0..E3, data_out_E0..E3    registered egress write strobes and data
//   cnt_E0..E3                      words delivered per destination (wrapping)
//   drop_cnt                        words rejected while stalled (saturating)
//   state                           00 IDLE, 01 ACTIVE, 10 BLOCKED
module demux_destino #(
   parameter int DATA_WIDTH = 10,
   parameter int BUF_DEPTH  = 4,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  stall,
   input  logic                  almost_full_E0,
   input  logic                  almost_full_E1,
   input  logic                  almost_full_E2,
   input  logic                  almost_full_E3,
   output logic                  push_E0,
   output logic                  push_E1,
   output logic                  push_E2,
   output logic                  push_E3,
   output logic [DATA_WIDTH-1:0] data_out_E0,
   output logic [DATA_WIDTH-1:0] data_out_E1,
   output logic [DATA_WIDTH-1:0] data_out_E2,
   output logic [DATA_WIDTH-1:0] data_out_E3,
   output logic [CNT_WIDTH-1:0]  cnt_E0,
   output logic [CNT_WIDTH-1:0]  cnt_E1,
   output logic [CNT_WIDTH-1:0]  cnt_E2,
   output logic [CNT_WIDTH-1:0]  cnt_E3,
   output logic [CNT_WIDTH-1:0]  drop_cnt,
   output logic [1:0]            state
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam logic [PTR_W:0] COUNT_FULL = (PTR_W+1)'(BUF_DEPTH);
   localparam logic [PTR_W:0] COUNT_ONE  = (PTR_W+1)'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ACTIVE  = 2'b01,
      BLOCKED = 2'b10
   } state_t;

   logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      rd_ptr_inc;
   logic [PTR_W:0]        count;
   logic [PTR_W:0]        count_next;

   logic [3:0]            almost_full;
   logic [DATA_WIDTH-1:0] head;
   logic [DATA_WIDTH-1:0] head_after;
   logic [1:0]            dest;
   logic [1:0]            dest_after;
   logic                  accept;
   logic                  pop;

   logic [3:0]            push_q;
   logic [DATA_WIDTH-1:0] data_q [4];
   logic [CNT_WIDTH-1:0]  cnt_q [4];
   logic [CNT_WIDTH-1:0]  drop_q;

   state_t                state_q;
   state_t                state_d;

   assign almost_full = {almost_full_E3, almost_full_E2, almost_full_E1, almost_full_E0};

   // stall looks at the stored count only, so a pop in the same cycle as a
   // full-buffer write does not make room for that write.
   assign stall      = (count == COUNT_FULL);
   assign accept     = push_in & ~stall;
   assign head       = mem[rd_ptr];
   assign dest       = head[DATA_WIDTH-1 -: 2];
   assign pop        = (count != '0) && !almost_full[dest];
   assign rd_ptr_inc = rd_ptr + 1'b1;
   assign dest_after = head_after[DATA_WIDTH-1 -: 2];

   // Buffer storage carries no reset; entries are only ever read when count
   // says they hold a valid word.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_ptr] <= data_in;
      end
   end

   // Occupancy after this edge: a simultaneous write and pop leaves it unchanged.
   always_comb begin
      count_next = count;
      if (accept && !pop) begin
         count_next = count + COUNT_ONE;
      end else if (!accept && pop) begin
         count_next = count - COUNT_ONE;
      end
   end

   // Pointers wrap naturally because BUF_DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr_inc;
         end
         count <= count_next;
      end
   end

   // Head word as it will be after this edge, used to decide whether the
   // next cycle starts out blocked. When the buffer drains to exactly the
   // incoming word, that word is not in mem yet, so take it from data_in.
   always_comb begin
      head_after = head;
      if (pop) begin
         if (count > COUNT_ONE) begin
            head_after = mem[rd_ptr_inc];
         end else begin
            head_after = data_in;
         end
      end else if (count == '0) begin
         head_after = data_in;
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // State reflects the post-update buffer: empty, flowing, or head blocked.
   always_comb begin
      state_d = IDLE;
      if (count_next != '0) begin
         if (almost_full[dest_after]) begin
            state_d = BLOCKED;
         end else begin
            state_d = ACTIVE;
         end
      end
   end

   assign state = state_q;

   // Egress delivery and statistics. Only the selected destination's data
   // register is written, so every data_out holds its last delivered word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         push_q <= '0;
         drop_q <= '0;
         for (int i = 0; i < 4; i++) begin
            data_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
      end else begin
         push_q <= '0;
         if (pop) begin
            push_q[dest] <= 1'b1;
            data_q[dest] <= head;
            cnt_q[dest]  <= cnt_q[dest] + 1'b1;
         end
         if (push_in && stall && (drop_q != '1)) begin
            drop_q <= drop_q + 1'b1;
         end
      end
   end

   assign push_E0     = push_q[0];
   assign push_E1     = push_q[1];
   assign push_E2     = push_q[2];
   assign push_E3     = push_q[3];
   assign data_out_E0 = data_q[0];
   assign data_out_E1 = data_q[1];
   assign data_out_E2 = data_q[2];
   assign data_out_E3 = data_q[3];
   assign cnt_E0      = cnt_q[0];
   assign cnt_E1      = cnt_q[1];
   assign cnt_E2      = cnt_q[2];
   assign cnt_E3      = cnt_q[3];
   assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_demux_destino.sv
// tb_demux_destino
// Directed-vector bench for demux_destino: single delivery and latency,
// back-to-back routing, head-of-line blocking, full-buffer drops, counter
// wrap and saturation, and asynchronous reset mid-stream.
module tb_demux_destino;

   logic       clk;
   logic       reset;
   logic       push_in;
   logic [9:0] data_in;
   logic       stall;
   logic       af0, af1, af2, af3;
   logic       push_E0, push_E1, push_E2, push_E3;
   logic [9:0] data_out_E0, data_out_E1, data_out_E2, data_out_E3;
   logic [7:0] cnt_E0, cnt_E1, cnt_E2, cnt_E3;
   logic [7:0] drop_cnt;
   logic [1:0] state;
   logic [3:0] pushes;

   int check_count;
   int error_count;

   demux_destino dut (
      .clk            (clk),
      .reset          (reset),
      .push_in        (push_in),
      .data_in        (data_in),
      .stall          (stall),
      .almost_full_E0 (af0),
      .almost_full_E1 (af1),
      .almost_full_E2 (af2),
      .almost_full_E3 (af3),
      .push_E0        (push_E0),
      .push_E1        (push_E1),
      .push_E2        (push_E2),
      .push_E3        (push_E3),
      .data_out_E0    (data_out_E0),
      .data_out_E1    (data_out_E1),
      .data_out_E2    (data_out_E2),
      .data_out_E3    (data_out_E3),
      .cnt_E0         (cnt_E0),
      .cnt_E1         (cnt_E1),
      .cnt_E2         (cnt_E2),
      .cnt_E3         (cnt_E3),
      .drop_cnt       (drop_cnt),
      .state          (state)
   );

   assign pushes = {push_E3, push_E2, push_E1, push_E0};

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive one upstream cycle, then sample 1 time unit after the rising edge.
   task automatic applyStimulus(input logic p, input logic [9:0] d);
      push_in = p;
      data_in = d;
      @(posedge clk);
      #1;
      push_in = 1'b0;
   endtask

   // Asynchronous reset pulse that does not line up with a clock edge.
   task automatic doReset();
      reset = 1'b1;
      #3;
      reset = 1'b0;
   endtask

   initial begin
      check_count = 0;
      error_count = 0;
      reset   = 1'b1;
      push_in = 1'b0;
      data_in = '0;
      {af3, af2, af1, af0} = 4'b0000;
      #12;
      reset = 1'b0;

      // Reset state
      checkOutput("rst_push",  32'(pushes),   0);
      checkOutput("rst_state", 32'(state),    0);
      checkOutput("rst_stall", 32'(stall),    0);
      checkOutput("rst_cnt2",  32'(cnt_E2),   0);
      checkOutput("rst_drop",  32'(drop_cnt), 0);

      // Single word to E2: push appears in the cycle after the second edge
      applyStimulus(1'b1, 10'h2A5);
      checkOutput("t1_push_early", 32'(pushes), 0);
      checkOutput("t1_state_act",  32'(state),  1);
      applyStimulus(1'b0, 10'h000);
      checkOutput("t1_push",  32'(pushes),      'b0100);
      checkOutput("t1_data",  32'(data_out_E2), 'h2A5);
      checkOutput("t1_cnt2",  32'(cnt_E2),      1);
      checkOutput("t1_idle",  32'(state),       0);
      applyStimulus(1'b0, 10'h000);
      checkOutput("t1_push_off", 32'(pushes),      0);
      checkOutput("t1_retain",   32'(data_out_E2), 'h2A5);

      // Back-to-back writes route to E0..E3 on consecutive cycles
      doReset();
      applyStimulus(1'b1, 10'h001);
      checkOutput("t2_p_none", 32'(pushes), 0);
      applyStimulus(1'b1, 10'h102);
      checkOutput("t2_p0", 32'(pushes),      'b0001);
      checkOutput("t2_d0", 32'(data_out_E0), 'h001);
      applyStimulus(1'b1, 10'h203);
      checkOutput("t2_p1", 32'(pushes),      'b0010);
      checkOutput("t2_d1", 32'(data_out_E1), 'h102);
      applyStimulus(1'b1, 10'h304);
      checkOutput("t2_p2", 32'(pushes),      'b0100);
      checkOutput("t2_d2", 32'(data_out_E2), 'h203);
      applyStimulus(1'b0, 10'h000);
      checkOutput("t2_p3",    32'(pushes),      'b1000);
      checkOutput("t2_d3",    32'(data_out_E3), 'h304);
      checkOutput("t2_state", 32'(state),       0);
      checkOutput("t2_cnt0",  32'(cnt_E0), 1);
      checkOutput("t2_cnt1",  32'(cnt_E1), 1);
      checkOutput("t2_cnt2",  32'(cnt_E2), 1);
      checkOutput("t2_cnt3",  32'(cnt_E3), 1);

      // Head-of-line blocking: E0 word waits behind blocked E1 word
      doReset();
      af1 = 1'b1;
      applyStimulus(1'b1, 10'h155);
      checkOutput("t3_blocked", 32'(state), 2);
      applyStimulus(1'b1, 10'h0AA);
      checkOutput("t3_p_none",  32'(pushes), 0);
      checkOutput("t3_blk2",    32'(state),  2);
      applyStimulus(1'b0, 10'h000);
      checkOutput("t3_hol", 32'(pushes), 0);
      af1 = 1'b0;
      applyStimulus(1'b0, 10'h000);
      checkOutput("t3_p1",    32'(pushes),      'b0010);
      checkOutput("t3_d1",    32'(data_out_E1), 'h155);
      checkOutput("t3_active", 32'(state),      1);
      applyStimulus(1'b0, 10'h000);
      checkOutput("t3_p0",    32'(pushes),      'b0001);
      checkOutput("t3_d0",    32'(data_out_E0), 'h0AA);
      checkOutput("t3_idle",  32'(state),       0);

      // Full buffer: words 5 and 6 dropped, first four delivered in order
      doReset();
      af3 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 10'(10'h300 + i));
      end
      checkOutput("t4_stall",     32'(stall),    1);
      checkOutput("t4_drop_zero", 32'(drop_cnt), 0);
      applyStimulus(1'b1, 10'h304);
      applyStimulus(1'b1, 10'h305);
      checkOutput("t4_drop",   32'(drop_cnt), 2);
      checkOutput("t4_p_none", 32'(pushes),   0);
      af3 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 10'h000);
         checkOutput("t4_p3", 32'(pushes),      'b1000);
         checkOutput("t4_d3", 32'(data_out_E3), 'h300 + i);
      end
      applyStimulus(1'b0, 10'h000);
      checkOutput("t4_p_end", 32'(pushes), 0);
      checkOutput("t4_cnt3",  32'(cnt_E3), 4);
      checkOutput("t4_idle",  32'(state),  0);

      // Delivery counter wraps; drop counter saturates
      doReset();
      for (int i = 0; i < 256; i++) begin
         applyStimulus(1'b1, 10'(i & 'hFF));
      end
      checkOutput("t5_cnt255", 32'(cnt_E0), 255);
      applyStimulus(1'b0, 10'h000);
      checkOutput("t5_wrap",   32'(cnt_E0),      0);
      checkOutput("t5_p0",     32'(pushes),      'b0001);
      checkOutput("t5_d0",     32'(data_out_E0), 'h0FF);
      af0 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 10'h011);
      end
      checkOutput("t5_stall", 32'(stall), 1);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 10'h012);
      end
      checkOutput("t5_drop10", 32'(drop_cnt), 10);
      for (int i = 0; i < 290; i++) begin
         applyStimulus(1'b1, 10'h013);
      end
      checkOutput("t5_sat",    32'(drop_cnt), 255);
      checkOutput("t5_p_none", 32'(pushes),   0);

      // Asynchronous reset with three words buffered
      doReset();
      af0 = 1'b0;
      af3 = 1'b1;
      applyStimulus(1'b1, 10'h010);
      applyStimulus(1'b1, 10'h300);
      checkOutput("t6_p0", 32'(pushes), 'b0001);
      applyStimulus(1'b1, 10'h301);
      applyStimulus(1'b1, 10'h302);
      checkOutput("t6_blk",  32'(state),       2);
      checkOutput("t6_cnt0", 32'(cnt_E0),      1);
      checkOutput("t6_d0",   32'(data_out_E0), 'h010);
      #3;
      reset = 1'b1;
      #1;
      checkOutput("t6_rst_d0",    32'(data_out_E0), 0);
      checkOutput("t6_rst_cnt0",  32'(cnt_E0),      0);
      checkOutput("t6_rst_state", 32'(state),       0);
      checkOutput("t6_rst_push",  32'(pushes),      0);
      #1;
      reset = 1'b0;
      af3 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 10'h000);
         checkOutput("t6_no_push", 32'(pushes), 0);
      end
      checkOutput("t6_cnt3", 32'(cnt_E3), 0);
      applyStimulus(1'b1, 10'h3C3);
      applyStimulus(1'b0, 10'h000);
      checkOutput("t6_new_p3", 32'(pushes),      'b1000);
      checkOutput("t6_new_d3", 32'(data_out_E3), 'h3C3);

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule
